// File: rtl/rbsp_bit_window_pkg.sv
// Shared constants and helper functions for the RBSP bit-window buffer.
//   BS_PEEK_W_DEFAULT      default window width in bits
//   BS_DEPTH_BYTES_DEFAULT default storage depth in bytes
//   clz()                  leading-zero count of the top w bits of a 64-bit value
//   tz8()                  trailing-zero count of a byte (8 when the byte is zero)
package rbsp_bit_window_pkg;

  localparam int BS_PEEK_W_DEFAULT      = 32;
  localparam int BS_DEPTH_BYTES_DEFAULT = 8;

  // Operand is left-aligned in 64 bits; only the top w bits are examined.
  // The last hit while scanning upward is the most significant set bit.
  function automatic int clz(input logic [63:0] v, input int w);
    int n;
    n = w;
    for (int i = 0; i < 64; i++) begin
      if ((i >= 64 - w) && v[i]) n = 63 - i;
    end
    return n;
  endfunction

  function automatic int tz8(input logic [7:0] b);
    int n;
    n = 8;
    for (int i = 7; i >= 0; i--) begin
      if (b[i]) n = i;
    end
    return n;
  endfunction

endpackage

// File: rtl/rbsp_bit_window_lzc.sv
// Parametrised leading-zero counter.
//   v   : operand, bit W-1 is the most significant
//   cnt : number of leading zeros, W when v is all zero
module bit_lzc
  import rbsp_bit_window_pkg::*;
#(
  parameter int W     = BS_PEEK_W_DEFAULT,
  parameter int LEN_W = 7
) (
  input  logic [W-1:0]     v,
  output logic [LEN_W-1:0] cnt
);

  logic [63:0] v64;

  assign v64 = 64'(v) << (64 - W);
  assign cnt = LEN_W'(clz(v64, W));

endmodule

// File: rtl/rbsp_bit_window.sv
// Bit-window buffer between the NAL byte reader and the syntax-element parsers.
// Holds RBSP bytes in a left-aligned shift register and presents the next
// PEEK_W bits MSB-first; parsers consume 0..PEEK_W bits per cycle.
//   clk, rst            clock, synchronous active-high reset
//   en                  global enable; low freezes all state
//   i_byte*             byte input with valid/ready handshake and last flag
//   i_fwd_valid/len     consume request
//   i_align             consume up to the next byte boundary (after any forward)
//   i_flush             drop contents, start a new NAL
//   o_window*           next PEEK_W bits (zero-padded) and their usability
//   o_lz_cnt            leading zeros of o_window
//   o_bits_avail        buffered bit count
//   o_more_rbsp_data    more_rbsp_data() result
//   o_err               sticky protocol error
module rbsp_bit_window
  import rbsp_bit_window_pkg::*;
#(
  parameter int PEEK_W      = BS_PEEK_W_DEFAULT,
  parameter int DEPTH_BYTES = BS_DEPTH_BYTES_DEFAULT,
  parameter int LEN_W       = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  input  logic              i_byte_last,
  output logic              o_byte_ready,
  input  logic              i_fwd_valid,
  input  logic [LEN_W-1:0]  i_fwd_len,
  input  logic              i_align,
  input  logic              i_flush,
  output logic [PEEK_W-1:0] o_window,
  output logic              o_window_valid,
  output logic [LEN_W-1:0]  o_lz_cnt,
  output logic [LEN_W-1:0]  o_bits_avail,
  output logic              o_more_rbsp_data,
  output logic              o_err
);

  localparam int SW = 8 * DEPTH_BYTES;
  localparam logic [LEN_W-1:0] PEEK_L = LEN_W'(PEEK_W);
  localparam logic [LEN_W-1:0] ROOM_L = LEN_W'(SW - 8);

  logic [SW-1:0]    buf_q, next_buf;
  logic [LEN_W-1:0] bits_avail, stop_bits;
  logic             end_seen;

  logic             consume_en, fwd_err, accept;
  logic [LEN_W-1:0] fwd_amt, after_fwd, align_amt, consumed, remain;
  logic [LEN_W-1:0] next_bits, next_stop;
  logic             next_end, next_err;

  always_comb begin
    consume_en = en & o_window_valid & ~i_flush;
    fwd_amt    = '0;
    fwd_err    = 1'b0;
    if (consume_en && i_fwd_valid) begin
      fwd_amt = (i_fwd_len > bits_avail) ? bits_avail : i_fwd_len;
      fwd_err = (i_fwd_len > PEEK_L) || (i_fwd_len > bits_avail);
    end
    after_fwd = bits_avail - fwd_amt;
    // Alignment is taken on the post-forward count so fwd+align is one step.
    align_amt = (consume_en && i_align) ? {{(LEN_W-3){1'b0}}, after_fwd[2:0]} : '0;
    consumed  = fwd_amt + align_amt;
    remain    = bits_avail - consumed;
  end

  assign o_byte_ready = en & ~end_seen & ~i_flush & (remain <= ROOM_L);
  assign accept       = o_byte_ready & i_byte_valid;

  // Bits beyond bits_avail are kept zero, so an OR inserts the new byte and
  // the window is zero-padded past the end of data for free.
  always_comb begin
    next_buf  = buf_q;
    next_bits = bits_avail;
    next_end  = end_seen;
    next_stop = stop_bits;
    next_err  = o_err;
    if (en) begin
      if (i_flush) begin
        next_buf  = '0;
        next_bits = '0;
        next_end  = 1'b0;
        next_stop = '0;
      end else begin
        next_buf  = buf_q << consumed;
        next_bits = remain;
        next_err  = o_err | fwd_err;
        if (accept) begin
          next_buf  = next_buf | ({i_byte, {(SW-8){1'b0}}} >> remain);
          next_bits = remain + LEN_W'(8);
          if (i_byte_last) begin
            next_end = 1'b1;
            if (i_byte == 8'h00) begin
              next_stop = '0;
              next_err  = 1'b1;
            end else begin
              next_stop = LEN_W'(tz8(i_byte) + 1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q            <= '0;
      bits_avail       <= '0;
      end_seen         <= 1'b0;
      stop_bits        <= '0;
      o_err            <= 1'b0;
      o_window_valid   <= 1'b0;
      o_more_rbsp_data <= 1'b1;
    end else begin
      buf_q            <= next_buf;
      bits_avail       <= next_bits;
      end_seen         <= next_end;
      stop_bits        <= next_stop;
      o_err            <= next_err;
      o_window_valid   <= (next_bits >= PEEK_L) | next_end;
      o_more_rbsp_data <= ~next_end | (next_bits > next_stop);
    end
  end

  assign o_window     = buf_q[SW-1 -: PEEK_W];
  assign o_bits_avail = bits_avail;

  bit_lzc #(.W(PEEK_W), .LEN_W(LEN_W)) u_lzc (
    .v   (o_window),
    .cnt (o_lz_cnt)
  );

endmodule
